ram_io_responder: RTL and testbench

Responder end of the CPU's byte-wide memory bus. It holds the 128 KB RAM and the memory-mapped I/O block.
- Serves byte reads with one cycle of registered latency, which is the CPU's 2-cycle read.
- Commits writes in the cycle they are presented.
- Bridges the 0x30000/0x30004 I/O addresses to an input byte FIFO, an output byte FIFO, a free-running cycle counter and a program-stop flag.
- Sits at top level next to `cpu`, facing the UART/host model.

---
 rtl/ram_io_responder.sv | 179 +++++++++++++++++
 tb/tb_ram_io_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ram_io_responder.sv
// Responder side of the CPU byte bus: 128 KB RAM plus memory-mapped I/O
// (RX/TX byte FIFOs, free-running cycle counter, program-stop flag).
module ram_io_responder #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned RX_DEPTH   = 16,
    parameter int unsigned TX_DEPTH   = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] bus_a,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_wr,
    output logic [7:0]  bus_rdata,
    output logic        io_full,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_stop,
    output logic        tx_overflow
);

    localparam int unsigned RAM_DEPTH = 32'd1 << ADDR_WIDTH;
    localparam int unsigned RX_AW     = $clog2(RX_DEPTH);
    localparam int unsigned TX_AW     = $clog2(TX_DEPTH);

    logic [7:0]       r_mem    [RAM_DEPTH];
    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [RX_AW:0]   r_rx_wp, r_rx_rp;
    logic [TX_AW:0]   r_tx_wp, r_tx_rp;
    logic [31:0]      r_cycle_cnt;
    logic [31:0]      r_cnt_latch;
    logic [18:0]      r_prev;
    logic             r_prev_valid;

    logic [18:0]      w_cur;
    logic             w_new;
    logic             w_is_io;
    logic             w_is_hole;
    logic [15:0]      w_io_off;
    logic [ADDR_WIDTH-1:0] w_ram_idx;
    logic             w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic             w_rx_push, w_rx_pop, w_tx_push, w_tx_pop, w_tx_req;
    logic [7:0]       w_tx_wdata;
    logic             w_set_stop, w_set_ovf, w_snap;
    logic             w_ram_we, w_rd_en, w_rd_ram;
    logic [7:0]       w_rd_io;
    logic             w_unused_bits;

    assign w_unused_bits = ^bus_a[31:18];

    assign w_cur     = {bus_a[17:0], bus_wr};
    assign w_new     = !r_prev_valid || (w_cur != r_prev);
    assign w_is_io   = (bus_a[17:16] == 2'b11);
    assign w_is_hole = (bus_a[17:16] == 2'b10);
    assign w_io_off  = bus_a[15:0];
    assign w_ram_idx = bus_a[ADDR_WIDTH-1:0];

    // Full: pointer wrap bits differ while index bits match
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[RX_AW] != r_rx_rp[RX_AW]) &&
                        (r_rx_wp[RX_AW-1:0] == r_rx_rp[RX_AW-1:0]);
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[TX_AW] != r_tx_rp[TX_AW]) &&
                        (r_tx_wp[TX_AW-1:0] == r_tx_rp[TX_AW-1:0]);

    assign rx_ready  = !w_rx_full;
    assign tx_valid  = !w_tx_empty;
    assign tx_data   = r_tx_mem[r_tx_rp[TX_AW-1:0]];
    assign io_full   = w_tx_full;

    assign w_rx_push = rx_valid && rx_ready;
    assign w_tx_pop  = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot a full-FIFO push needs
    assign w_tx_push = w_tx_req && (!w_tx_full || w_tx_pop);
    assign w_set_ovf = w_tx_req && w_tx_full && !w_tx_pop;

    // Bus decode and I/O side-effect selection
    always_comb begin
        w_rx_pop   = 1'b0;
        w_tx_req   = 1'b0;
        w_tx_wdata = 8'h00;
        w_set_stop = 1'b0;
        w_snap     = 1'b0;
        w_ram_we   = 1'b0;
        w_rd_en    = 1'b0;
        w_rd_ram   = 1'b0;
        w_rd_io    = 8'h00;
        if (bus_wr) begin
            if (w_is_io) begin
                if (w_new) begin
                    case (w_io_off)
                        16'h0000: begin
                            w_tx_req   = (bus_wdata != 8'h00);
                            w_tx_wdata = bus_wdata;
                        end
                        16'h0004: begin
                            w_tx_req   = 1'b1;
                            w_set_stop = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else if (!w_is_hole) begin
                w_ram_we = 1'b1;
            end
        end else begin
            w_rd_en = 1'b1;
            if (w_is_io) begin
                case (w_io_off)
                    16'h0000: begin
                        if (w_new) begin
                            if (!w_rx_empty) begin
                                w_rx_pop = 1'b1;
                                w_rd_io  = r_rx_mem[r_rx_rp[RX_AW-1:0]];
                            end
                        end else begin
                            w_rd_en = 1'b0;
                        end
                    end
                    16'h0004: begin
                        w_rd_io = r_cycle_cnt[7:0];
                        w_snap  = w_new;
                    end
                    16'h0005: w_rd_io = r_cnt_latch[15:8];
                    16'h0006: w_rd_io = r_cnt_latch[23:16];
                    16'h0007: w_rd_io = r_cnt_latch[31:24];
                    default:  w_rd_io = 8'h00;
                endcase
            end else if (!w_is_hole) begin
                w_rd_ram = 1'b1;
            end
        end
    end

    // Control state, counters and registered read data
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bus_rdata    <= 8'h00;
            prog_stop    <= 1'b0;
            tx_overflow  <= 1'b0;
            r_cycle_cnt  <= 32'd0;
            r_cnt_latch  <= 32'd0;
            r_rx_wp      <= '0;
            r_rx_rp      <= '0;
            r_tx_wp      <= '0;
            r_tx_rp      <= '0;
            r_prev       <= 19'd0;
            r_prev_valid <= 1'b0;
        end else begin
            r_cycle_cnt  <= r_cycle_cnt + 32'd1;
            r_prev       <= w_cur;
            r_prev_valid <= 1'b1;
            if (w_rd_en) begin
                bus_rdata <= w_rd_ram ? r_mem[w_ram_idx] : w_rd_io;
            end
            if (w_snap)     r_cnt_latch <= r_cycle_cnt;
            if (w_set_stop) prog_stop   <= 1'b1;
            if (w_set_ovf)  tx_overflow <= 1'b1;
            if (w_rx_push)  r_rx_wp <= r_rx_wp + (RX_AW+1)'(1);
            if (w_rx_pop)   r_rx_rp <= r_rx_rp + (RX_AW+1)'(1);
            if (w_tx_push)  r_tx_wp <= r_tx_wp + (TX_AW+1)'(1);
            if (w_tx_pop)   r_tx_rp <= r_tx_rp + (TX_AW+1)'(1);
        end
    end

    // Storage arrays carry no reset; writes are blocked while reset is held
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            if (w_ram_we)  r_mem[w_ram_idx] <= bus_wdata;
            if (w_rx_push) r_rx_mem[r_rx_wp[RX_AW-1:0]] <= rx_data;
            if (w_tx_push) r_tx_mem[r_tx_wp[TX_AW-1:0]] <= w_tx_wdata;
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed self-checking bench for ram_io_responder: RAM, RX pop, counter
// snapshot, TX filtering, overflow and mid-run reset.
module tb_ram_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] bus_a;
    logic [7:0]  bus_wdata;
    logic        bus_wr;
    logic [7:0]  bus_rdata;
    logic        io_full;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        prog_stop;
    logic        tx_overflow;

    int n_vec = 0;
    int n_err = 0;
    int tb_edges;
    logic [31:0] exp_cnt;

    ram_io_responder #(.ADDR_WIDTH(17), .RX_DEPTH(16), .TX_DEPTH(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .bus_a(bus_a), .bus_wdata(bus_wdata), .bus_wr(bus_wr),
        .bus_rdata(bus_rdata), .io_full(io_full),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .prog_stop(prog_stop), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Reference count of clock edges since reset release
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) tb_edges <= 0;
        else        tb_edges <= tb_edges + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic bus_rd(input logic [31:0] a);
        bus_a = a; bus_wr = 1'b0; cyc(1);
    endtask

    // One-cycle write followed by a parking read so the next write is new
    task automatic io_wr(input logic [31:0] a, input logic [7:0] d);
        bus_a = a; bus_wr = 1'b1; bus_wdata = d; cyc(1);
        bus_a = 32'h0000_0123; bus_wr = 1'b0; cyc(1);
    endtask

    initial begin
        rst_in = 1'b1; bus_a = 32'h0; bus_wdata = 8'h0; bus_wr = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h0; tx_ready = 1'b0;
        #3;
        check("rst_rdata", 32'(bus_rdata), 32'h00);
        check("rst_stop",  32'(prog_stop), 32'h0);
        check("rst_ovf",   32'(tx_overflow), 32'h0);
        check("rst_rxrdy", 32'(rx_ready), 32'h1);
        check("rst_txval", 32'(tx_valid), 32'h0);
        check("rst_full",  32'(io_full), 32'h0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // RAM write/read, hole region, hold during write
        bus_a = 32'h0000_0123; bus_wr = 1'b1; bus_wdata = 8'hA5; cyc(1);
        bus_wr = 1'b0; cyc(1);
        check("ram_rd_a5", 32'(bus_rdata), 32'hA5);
        bus_a = 32'h0000_5000; bus_wr = 1'b1; bus_wdata = 8'h11; cyc(1);
        bus_a = 32'h0002_5000; bus_wr = 1'b0; cyc(1);
        check("hole_rd", 32'(bus_rdata), 32'h00);
        bus_a = 32'h0002_5000; bus_wr = 1'b1; bus_wdata = 8'h55; cyc(1);
        bus_rd(32'h0000_5000);
        check("hole_wr_ignored", 32'(bus_rdata), 32'h11);
        bus_a = 32'h0000_0200; bus_wr = 1'b1; bus_wdata = 8'h77; cyc(1);
        check("hold_on_write", 32'(bus_rdata), 32'h11);
        bus_rd(32'h0000_0200);
        check("ram_rd_77", 32'(bus_rdata), 32'h77);

        // RX pop with held address
        rx_valid = 1'b1; rx_data = 8'h41; cyc(1);
        rx_data = 8'h42; cyc(1);
        rx_valid = 1'b0;
        bus_rd(32'h0003_0000);
        check("rx_pop1", 32'(bus_rdata), 32'h41);
        cyc(1);
        check("rx_hold1", 32'(bus_rdata), 32'h41);
        cyc(1);
        check("rx_hold2", 32'(bus_rdata), 32'h41);
        bus_rd(32'h0000_0123);
        bus_rd(32'h0003_0000);
        check("rx_pop2", 32'(bus_rdata), 32'h42);
        bus_rd(32'h0000_0123);
        bus_rd(32'h0003_0000);
        check("rx_empty", 32'(bus_rdata), 32'h00);
        // Empty FIFO: same-cycle push and pop returns 0, byte stays queued
        bus_rd(32'h0000_0123);
        bus_a = 32'h0003_0000; rx_valid = 1'b1; rx_data = 8'h99; cyc(1);
        rx_valid = 1'b0;
        check("rx_same_cycle", 32'(bus_rdata), 32'h00);
        bus_rd(32'h0000_0123);
        bus_rd(32'h0003_0000);
        check("rx_queued", 32'(bus_rdata), 32'h99);

        // Counter coherence
        bus_a = 32'h0000_0123; cyc(300);
        bus_a = 32'h0003_0004; exp_cnt = 32'(tb_edges); cyc(1);
        check("cnt_b0", 32'(bus_rdata), 32'(exp_cnt[7:0]));
        bus_rd(32'h0003_0005);
        check("cnt_b1", 32'(bus_rdata), 32'(exp_cnt[15:8]));
        bus_rd(32'h0003_0006);
        check("cnt_b2", 32'(bus_rdata), 32'(exp_cnt[23:16]));
        bus_rd(32'h0003_0007);
        check("cnt_b3", 32'(bus_rdata), 32'(exp_cnt[31:24]));
        bus_rd(32'h0003_0010);
        check("io_other", 32'(bus_rdata), 32'h00);

        // TX zero filter and program stop
        io_wr(32'h0003_0000, 8'h00);
        check("tx_zero_filtered", 32'(tx_valid), 32'h0);
        io_wr(32'h0003_0000, 8'h48);
        io_wr(32'h0003_0000, 8'h69);
        check("tx_v1", 32'(tx_valid), 32'h1);
        check("tx_d1", 32'(tx_data), 32'h48);
        tx_ready = 1'b1; cyc(1); tx_ready = 1'b0;
        check("tx_d2", 32'(tx_data), 32'h69);
        tx_ready = 1'b1; cyc(1); tx_ready = 1'b0;
        check("tx_drained", 32'(tx_valid), 32'h0);
        check("stop_clear", 32'(prog_stop), 32'h0);
        io_wr(32'h0003_0004, 8'h33);
        check("stop_tx_v", 32'(tx_valid), 32'h1);
        check("stop_tx_d", 32'(tx_data), 32'h00);
        check("stop_set", 32'(prog_stop), 32'h1);
        tx_ready = 1'b1; cyc(1); tx_ready = 1'b0;

        // Overflow: 17 bytes into a 16-deep FIFO with the host stalled
        for (int i = 0; i < 15; i++) io_wr(32'h0003_0000, 8'(8'h10 + i));
        check("full_after15", 32'(io_full), 32'h0);
        io_wr(32'h0003_0000, 8'h1F);
        check("full_after16", 32'(io_full), 32'h1);
        check("ovf_after16", 32'(tx_overflow), 32'h0);
        io_wr(32'h0003_0000, 8'h20);
        check("ovf_after17", 32'(tx_overflow), 32'h1);
        for (int i = 0; i < 16; i++) begin
            check("drain_v", 32'(tx_valid), 32'h1);
            check("drain_d", 32'(tx_data), 32'(8'h10 + i));
            tx_ready = 1'b1; cyc(1); tx_ready = 1'b0;
        end
        check("drain_empty", 32'(tx_valid), 32'h0);
        check("full_clear", 32'(io_full), 32'h0);

        // Reset mid-run with FIFOs partly full
        rx_valid = 1'b1; rx_data = 8'h7E; cyc(1); rx_valid = 1'b0;
        io_wr(32'h0003_0000, 8'h55);
        check("pre_rst_txv", 32'(tx_valid), 32'h1);
        rst_in = 1'b1; #1;
        check("mrst_rdata", 32'(bus_rdata), 32'h00);
        check("mrst_stop",  32'(prog_stop), 32'h0);
        check("mrst_ovf",   32'(tx_overflow), 32'h0);
        check("mrst_txval", 32'(tx_valid), 32'h0);
        check("mrst_full",  32'(io_full), 32'h0);
        check("mrst_rxrdy", 32'(rx_ready), 32'h1);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        bus_rd(32'h0000_0123);
        check("ram_keep_a5", 32'(bus_rdata), 32'hA5);
        bus_rd(32'h0000_5000);
        check("ram_keep_11", 32'(bus_rdata), 32'h11);
        bus_rd(32'h0003_0000);
        check("rx_flushed", 32'(bus_rdata), 32'h00);
        bus_rd(32'h0003_0005);
        check("latch_reset", 32'(bus_rdata), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
